// File: rtl/alu_operand_framer.sv
// alu_operand_framer: assembles A/B/expected-parity nibble frames for the parity stage,
// pulses E for one cycle, then flags and counts mismatches against the returned parity.
module alu_operand_framer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    input  logic             clr_cnt,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic             E,
    input  logic             ansA,
    input  logic             ansB,
    output logic             frame_done,
    output logic [1:0]       parity_err,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {S_A, S_B, S_P, S_EVAL} state_t;
    state_t     state, state_nx;
    logic [1:0] exp_par;
    logic [1:0] mis;
    logic       xfer;
    always_comb begin
        din_ready = state != S_EVAL;
        E         = state == S_EVAL;
        // abort wins over a same-cycle transfer, so the nibble is left on the bus
        xfer      = din_valid && din_ready && !abort;
        mis       = {ansA ^ exp_par[1], ansB ^ exp_par[0]};
        state_nx  = (E || abort) ? S_A : xfer ? state_t'(state + 2'd1) : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            a          <= '0;
            b          <= '0;
            exp_par    <= '0;
            parity_err <= '0;
            frame_done <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= E;
            if (xfer && state == S_A) a <= din;
            if (xfer && state == S_B) b <= din;
            if (abort && !E) exp_par <= '0;
            else if (xfer && state == S_P) exp_par <= din[1:0];
            if (E) parity_err <= mis;
            if (clr_cnt) err_count <= '0;
            else if (E && |mis && !(&err_count)) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_operand_framer.sv
// tb_alu_operand_framer: directed frames against two framers (CNT_W=8 and CNT_W=2)
// sharing one stimulus stream, with the parity stage modelled as a reduction XOR.
module tb_alu_operand_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0, abort = 1'b0, clr_cnt = 1'b0;
    logic       din_ready, E, ans_a, ans_b, frame_done;
    logic [3:0] a, b;
    logic [1:0] parity_err;
    logic [7:0] err_count;
    logic       din_ready2, E2, ans_a2, ans_b2, frame_done2;
    logic [3:0] a2, b2;
    logic [1:0] parity_err2;
    logic [1:0] err_count2;
    int         checks = 0, errors = 0;
    int         cnt8 = 0, cnt2 = 0;

    always #5 clk = ~clk;
    assign ans_a  = ^a;
    assign ans_b  = ^b;
    assign ans_a2 = ^a2;
    assign ans_b2 = ^b2;

    alu_operand_framer #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .abort(abort), .clr_cnt(clr_cnt), .a(a), .b(b), .E(E), .ansA(ans_a), .ansB(ans_b),
        .frame_done(frame_done), .parity_err(parity_err), .err_count(err_count)
    );
    alu_operand_framer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready2),
        .abort(abort), .clr_cnt(clr_cnt), .a(a2), .b(b2), .E(E2), .ansA(ans_a2), .ansB(ans_b2),
        .frame_done(frame_done2), .parity_err(parity_err2), .err_count(err_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one nibble offered for one cycle; entered and left #1 after a rising edge
    task automatic put(input logic [3:0] n);
        din = n;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // called in the EVAL cycle; offers a nibble that must stall, optionally clears the counter
    task automatic eval_chk(input logic [3:0] x, input logic [3:0] y, input logic [1:0] p, input logic clr);
        logic [1:0] pe;
        pe = {(^x) ^ p[1], (^y) ^ p[0]};
        check("E_eval", E, 1);
        check("rdy_eval", din_ready, 0);
        check("a_eval", a, x);
        check("b_eval", b, y);
        check("fd_eval", frame_done, 0);
        din = 4'hF;
        din_valid = 1'b1;
        clr_cnt = clr;
        @(posedge clk); #1;
        din_valid = 1'b0;
        clr_cnt = 1'b0;
        cnt8 = clr ? 0 : (pe != 0 && cnt8 != 255) ? cnt8 + 1 : cnt8;
        cnt2 = clr ? 0 : (pe != 0 && cnt2 != 3) ? cnt2 + 1 : cnt2;
        check("fd", frame_done, 1);
        check("pe", parity_err, pe);
        check("cnt8", err_count, cnt8);
        check("cnt2", err_count2, cnt2);
        check("E_done", E, 0);
        check("rdy_done", din_ready, 1);
        check("a_hold", a, x);
    endtask

    task automatic frame(input logic [3:0] x, input logic [3:0] y, input logic [3:0] p, input logic clr);
        put(x);
        put(y);
        put(p);
        eval_chk(x, y, p[1:0], clr);
    endtask

    initial begin
        #2;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_E", E, 0);
        check("rst_rdy", din_ready, 1);
        check("rst_fd", frame_done, 0);
        check("rst_pe", parity_err, 0);
        check("rst_cnt", err_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        // 1: matching frame, then one-cycle pulse and held parity_err
        frame(4'hB, 4'h6, 4'h2, 1'b0);
        @(posedge clk); #1;
        check("fd_pulse", frame_done, 0);
        check("pe_hold", parity_err, 0);
        // 2: both bits wrong, then a clean frame
        frame(4'hB, 4'h6, 4'h1, 1'b0);
        frame(4'h0, 4'hF, 4'h0, 1'b0);
        // 3: gap after operand A
        put(4'h3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("gap_E", E, 0);
        end
        put(4'h8);
        put(4'h1);
        eval_chk(4'h3, 4'h8, 2'b01, 1'b0);
        // 4: abort beats a simultaneous valid nibble
        put(4'h5);
        din = 4'h9;
        din_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        abort = 1'b0;
        check("abort_E", E, 0);
        check("abort_rdy", din_ready, 1);
        check("abort_a", a, 4'h5);
        check("abort_b", b, 4'h8);
        frame(4'h7, 4'h0, 4'h2, 1'b0);
        // 5: saturation of the 2-bit counter, then clear against an increment
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        cnt8 = 0;
        cnt2 = 0;
        check("clr8", err_count, 0);
        check("clr2", err_count2, 0);
        for (int i = 0; i < 4; i++) frame(4'hB, 4'h6, 4'h1, 1'b0);
        check("sat2", err_count2, 3);
        check("cnt8_4", err_count, 4);
        frame(4'hB, 4'h6, 4'h1, 1'b1);
        // 6: asynchronous reset mid-frame
        frame(4'hB, 4'h6, 4'h1, 1'b0);
        put(4'h4);
        put(4'h5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a", a, 0);
        check("arst_b", b, 0);
        check("arst_pe", parity_err, 0);
        check("arst_cnt", err_count, 0);
        check("arst_rdy", din_ready, 1);
        check("arst_E", E, 0);
        cnt8 = 0;
        cnt2 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(4'h1, 4'h1, 4'h3, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
